// File: rtl/fb_pattern_writer.sv
// Fills an SDRAM frame buffer with a 16-pixel white grid over Avalon-MM bursts.
// Optional FB_CONTINUOUS_EN: refill frames back-to-back with a scrolling x offset.
module fb_pattern_writer #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned BURSTSIZE = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] address,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic [7:0]  burstcount,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NBURSTS = HDISP * VDISP / BURSTSIZE;
  localparam int unsigned XW      = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW      = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW      = (BURSTSIZE > 1) ? $clog2(BURSTSIZE) : 1;
  localparam int unsigned IW      = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  if (BURSTSIZE == 0 || BURSTSIZE > 255) begin : g_bad_burst
    $error("fb_pattern_writer: BURSTSIZE must be 1..255");
  end
  if ((HDISP * VDISP) % BURSTSIZE != 0) begin : g_bad_geom
    $error("fb_pattern_writer: HDISP*VDISP must be a multiple of BURSTSIZE");
  end

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] bidx_q, bidx_d;
  logic          accept;
  logic          last_burst;
  logic [7:0]    x_pat;
  logic [7:0]    y_pat;

`ifdef FB_CONTINUOUS_EN
  logic [7:0] frame_q, frame_d;
  assign x_pat = 8'(x_q) + frame_q;
`else
  assign x_pat = 8'(x_q);
`endif
  assign y_pat = 8'(y_q);

  assign write      = (state_q == BURST);
  assign busy       = (state_q != IDLE);
  assign last_burst = (bidx_q == IW'(NBURSTS - 1));
  assign done       = (state_q == GAP) && last_burst;
  assign accept     = write && !waitrequest;
  assign address    = BASE_ADDR + 32'(bidx_q) * (32'(BURSTSIZE) << 2);
  assign writedata  = (x_pat[3:0] == 4'hF || y_pat[3:0] == 4'hF) ? 32'h00FF_FFFF : 32'h0;
  assign byteenable = 4'hF;
  assign burstcount = 8'(BURSTSIZE);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    bidx_d  = bidx_q;
`ifdef FB_CONTINUOUS_EN
    frame_d = frame_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = BURST;
      end
      BURST: begin
        if (accept) begin
          // Raster advance; total beats equal HDISP*VDISP so x/y wrap to 0 with the frame.
          if (x_q == XW'(HDISP - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(VDISP - 1)) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (beat_q == BW'(BURSTSIZE - 1)) begin
            beat_d  = '0;
            state_d = GAP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (last_burst) begin
          bidx_d = '0;
`ifdef FB_CONTINUOUS_EN
          frame_d = frame_q + 8'd1;
          state_d = BURST;
`else
          state_d = IDLE;
`endif
        end else begin
          bidx_d  = bidx_q + 1'b1;
          state_d = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      bidx_q  <= '0;
`ifdef FB_CONTINUOUS_EN
      frame_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      bidx_q  <= bidx_d;
`ifdef FB_CONTINUOUS_EN
      frame_q <= frame_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a 32x2 frame with 16-word bursts at 0x1000.
module tb_fb_pattern_writer;

  localparam int unsigned HD = 32;
  localparam int unsigned VD = 2;
  localparam int unsigned BS = 16;
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] WHITE = 32'h00FF_FFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [7:0]  burstcount;
  logic        waitrequest;
  logic        busy;
  logic        done;

  int tests;
  int fails;
  int nbeats;
  int ndone;
  int nbusy;
  int ngaps;
  logic [31:0] data_log [256];
  logic [31:0] addr_log [256];
  logic [31:0] sa;
  logic [31:0] sd;
  int g;

  fb_pattern_writer #(
    .HDISP    (HD),
    .VDISP    (VD),
    .BURSTSIZE(BS),
    .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .byteenable (byteenable),
    .burstcount (burstcount),
    .waitrequest(waitrequest),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the values the DUT presents to the next edge, then advances one cycle.
  task automatic cyc();
    if (write && !waitrequest) begin
      if (nbeats < 256) begin
        data_log[nbeats] = writedata;
        addr_log[nbeats] = address;
      end
      nbeats++;
    end
    if (done) ndone++;
    if (busy) nbusy++;
    if (busy && !write) ngaps++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    nbeats = 0;
    ndone  = 0;
    nbusy  = 0;
    ngaps  = 0;
  endtask

  function automatic logic [31:0] exp_word(input int i, input int f);
    int x;
    int y;
    x = ((i % HD) + f) % 256;
    y = i / HD;
    return ((x % 16 == 15) || (y % 16 == 15)) ? WHITE : 32'h0;
  endfunction

  task automatic check_frame(input string tag, input int base, input int f);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_data%0d", tag, i), data_log[base + i], exp_word(i, f));
      check($sformatf("%s_addr%0d", tag, i), addr_log[base + i],
            BASE + 32'((i / BS) * BS * 4));
    end
  endtask

  task automatic run_until_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 500) begin
      cyc();
      k++;
    end
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    waitrequest = 1'b0;
    clear_logs();
    @(posedge clk);
    #1;
    do_reset();

    check("rst_write", 32'(write), 32'h0);
    check("rst_addr", address, BASE);
    check("rst_data", writedata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("byteenable", 32'(byteenable), 32'hF);
    check("burstcount", 32'(burstcount), 32'd16);

`ifdef FB_CONTINUOUS_EN
    // Continuous: final burst wraps straight back to BASE with the grid shifted by one.
    clear_logs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    g = 0;
    while (nbeats < 64 && g < 300) begin
      cyc();
      g++;
    end
    check("cont_gap_done", 32'(done), 32'h1);
    check("cont_gap_busy", 32'(busy), 32'h1);
    check("cont_gap_write", 32'(write), 32'h0);
    cyc();
    check("cont_wrap_busy", 32'(busy), 32'h1);
    check("cont_wrap_write", 32'(write), 32'h1);
    check("cont_wrap_addr", address, BASE);
    g = 0;
    while (nbeats < 80 && g < 100) begin
      cyc();
      g++;
    end
    check("cont_beats", 32'(nbeats), 32'd80);
    check("cont_f1_w14", data_log[14], 32'h0);
    check("cont_f1_w15", data_log[15], WHITE);
    check("cont_f2_w14", data_log[78], WHITE);
    check("cont_f2_w15", data_log[79], 32'h0);
    check("cont_ndone", 32'(ndone), 32'd1);
    do_reset();
    check("cont_rst_busy", 32'(busy), 32'h0);
`else
    // Plain frame fill with no stalls.
    clear_logs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("f1_first_write", 32'(write), 32'h1);
    check("f1_first_addr", address, BASE);
    run_until_idle("f1");
    check("f1_beats", 32'(nbeats), 32'd64);
    check("f1_ndone", 32'(ndone), 32'd1);
    check("f1_gaps", 32'(ngaps), 32'd4);
    check("f1_busy_cycles", 32'(nbusy), 32'd68);
    check("f1_w14", data_log[14], 32'h0);
    check("f1_w15", data_log[15], WHITE);
    check("f1_w31", data_log[31], WHITE);
    check("f1_b1_addr", addr_log[16], 32'h1040);
    check("f1_b3_addr", addr_log[48], 32'h10C0);
    check_frame("f1", 0, 0);

    // Stall on beat 5 of burst 2.
    clear_logs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    g = 0;
    while (nbeats < 37 && g < 100) begin
      cyc();
      g++;
    end
    check("st_pre_write", 32'(write), 32'h1);
    sa = address;
    sd = writedata;
    check("st_addr_val", sa, 32'h1080);
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("st_write%0d", i), 32'(write), 32'h1);
      check($sformatf("st_addr%0d", i), address, sa);
      check($sformatf("st_data%0d", i), writedata, sd);
    end
    waitrequest = 1'b0;
    run_until_idle("st");
    check("st_beats", 32'(nbeats), 32'd64);
    check("st_busy_cycles", 32'(nbusy), 32'd71);
    check_frame("st", 0, 0);

    // Reset on beat 8 of burst 1 aborts; a new start begins from scratch.
    clear_logs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    g = 0;
    while (nbeats < 24 && g < 100) begin
      cyc();
      g++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("ra_write", 32'(write), 32'h0);
    check("ra_busy", 32'(busy), 32'h0);
    check("ra_done", 32'(done), 32'h0);
    check("ra_addr", address, BASE);
    check("ra_data", writedata, 32'h0);
    cyc();
    check("ra_still_idle", 32'(write), 32'h0);
    clear_logs();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("ra_restart_addr", address, BASE);
    check("ra_restart_write", 32'(write), 32'h1);
    run_until_idle("ra");
    check("ra_beats", 32'(nbeats), 32'd64);
    check_frame("ra", 0, 0);

    // Start held high: second frame follows one IDLE cycle; extra pulse mid-burst ignored.
    clear_logs();
    start = 1'b1;
    cyc();
    g = 0;
    while (!done && g < 200) begin
      cyc();
      g++;
    end
    check("hold_done", 32'(done), 32'h1);
    check("hold_done_busy", 32'(busy), 32'h1);
    cyc();
    check("hold_idle_busy", 32'(busy), 32'h0);
    check("hold_idle_addr", address, BASE);
    cyc();
    check("hold_f2_busy", 32'(busy), 32'h1);
    check("hold_f2_write", 32'(write), 32'h1);
    check("hold_f2_addr", address, BASE);
    start = 1'b0;
    repeat (5) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_idle("hold");
    check("hold_beats", 32'(nbeats), 32'd128);
    check("hold_ndone", 32'(ndone), 32'd2);
    check_frame("hold_f1", 0, 0);
    check_frame("hold_f2", 64, 0);
    repeat (3) cyc();
    check("hold_end_idle", 32'(busy), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_pattern_writer.md
FB_PATTERN_WRITER -- requirements
Module: fb_pattern_writer

Interface
REQ-001 The block SHALL have parameter HDISP, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter VDISP, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter BURSTSIZE, default 16, meaning 32-bit words per Avalon write burst.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of pixel (0,0) in SDRAM.
REQ-005 The block SHALL have port clk, input, 1, the single clock (Avalon/SDRAM domain).
REQ-006 The block SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1, request to fill one frame; sampled only in IDLE.
REQ-008 The block SHALL have port address, output, 32, Avalon burst byte address.
REQ-009 The block SHALL have port write, output, 1, Avalon write request.
REQ-010 The block SHALL have port writedata, output, 32, pixel word: [23:0] RGB, [31:24] zero.
REQ-011 The block SHALL have port byteenable, output, 4, constant 4'hF.
REQ-012 The block SHALL have port burstcount, output, 8, constant BURSTSIZE.
REQ-013 The block SHALL have port waitrequest, input, 1, Avalon slave stall.
REQ-014 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when the last word of a frame is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, BURST, GAP; IDLE->BURST on start, BURST->GAP on acceptance of the last beat of a burst, GAP->BURST if frame words remain, GAP->IDLE otherwise.
REQ-017 A beat SHALL be accepted exactly on a cycle with write=1 and waitrequest=0; write, address, burstcount and writedata SHALL be held stable while waitrequest=1.
REQ-018 write SHALL be 1 for every cycle in BURST and 0 in IDLE and GAP (GAP lasts exactly one cycle).
REQ-019 address SHALL equal BASE_ADDR + 4*BURSTSIZE*burst_index, constant across a burst, incrementing by 4*BURSTSIZE in GAP.
REQ-020 Pixel coordinates x (0..HDISP-1) and y (0..VDISP-1) SHALL advance raster-order per accepted beat, x wrapping to 0 and y incrementing at x=HDISP-1.
REQ-021 writedata SHALL be 32'h00FFFFFF when x[3:0]==15 or y[3:0]==15, else 32'h0.
REQ-022 A frame SHALL consist of exactly HDISP*VDISP/BURSTSIZE bursts; HDISP*VDISP not a multiple of BURSTSIZE SHALL be a parameter error (elaboration-time assertion).
REQ-023 done SHALL pulse in the GAP cycle following the final beat; busy SHALL drop one cycle later.
REQ-024 start asserted while busy=1 SHALL be ignored; start held high in IDLE after done SHALL begin a new frame at BASE_ADDR.

Reset
REQ-025 On reset=1 at a clock edge, the next cycle SHALL show write=0, address=BASE_ADDR, writedata=0, busy=0, done=0, state IDLE, x=y=0, burst_index=0.
REQ-026 Reset mid-burst SHALL abort the burst without completing remaining beats; reset has priority over all other events.

Configuration
REQ-027 Macro FB_CONTINUOUS_EN: when defined, the block SHALL go GAP->BURST at BASE_ADDR after the final burst (no IDLE), pulsing done per frame, and SHALL add an 8-bit frame counter to x before the pattern test (scrolling grid); when undefined, behaviour is single-shot per REQ-016/REQ-024 with no frame counter.

Verification (bench params HDISP=32, VDISP=2, BURSTSIZE=16, BASE_ADDR=32'h1000, macro undefined unless stated)
REQ-028 start pulse, waitrequest=0 -> 4 bursts at 0x1000,0x1040,0x1080,0x10C0, 16 beats each, 1-cycle write=0 gaps, done pulse once, 64 words total.
REQ-029 Data check -> word index 15 and 31 = 0x00FFFFFF, index 14 = 0x0; line y=1 identical to y=0.
REQ-030 waitrequest=1 for 3 cycles on beat 5 of burst 2 -> write, address, writedata unchanged during stall, no beat lost or duplicated.
REQ-031 reset asserted on beat 8 of burst 1 -> write=0 next cycle, busy=0; subsequent start restarts at 0x1000 with word 0.
REQ-032 start held high through a frame -> second frame begins in cycle after IDLE is re-entered; start pulse during BURST has no effect.
REQ-033 FB_CONTINUOUS_EN defined -> after 4th burst next burst at 0x1000 with no IDLE; frame 2 word 14 = 0x00FFFFFF (x offset 1).
